// File: rtl/ball_pixel_gen_pkg.sv
// -----------------------------------------------------------------------------
// pixel_gen_pkg
// Shared definitions for the ball/board pixel generator:
//   - state_t   : game FSM encoding (SERVE, PLAY, MISS)
//   - coord_t   : 11-bit unsigned coordinate, one bit wider than the VGA
//                 counters so that "edge + width" sums never wrap
//   - DEF_*     : default screen size and colours
//   - inSpan()  : half-open range test used for all rectangle hit tests
// -----------------------------------------------------------------------------
package pixel_gen_pkg;

    typedef enum logic [1:0] {
        SERVE = 2'd0,
        PLAY  = 2'd1,
        MISS  = 2'd2
    } state_t;

    localparam int DEF_H_ACTIVE = 640;
    localparam int DEF_V_ACTIVE = 480;

    localparam logic [11:0] DEF_BALL_RGB  = 12'h0FF;
    localparam logic [11:0] DEF_BOARD_RGB = 12'hFFF;
    localparam logic [11:0] DEF_BG_RGB    = 12'h0F0;
    localparam logic [11:0] BLANK_RGB     = 12'h000;

    localparam int COORD_W = 11;
    typedef logic [COORD_W-1:0] coord_t;

    // True when p lies in [lo, lo + len). Both sides stay 11 bits wide, so
    // a 10-bit edge plus a small width cannot wrap back to zero.
    function automatic logic inSpan(coord_t p, coord_t lo, coord_t len);
        return (p >= lo) && (p < lo + len);
    endfunction

endpackage

// File: rtl/ball_pixel_gen_if.sv
// -----------------------------------------------------------------------------
// ball_pixel_gen_if
// Bundles the pixel-stream inputs and game outputs of ball_pixel_gen.
//   video_on, x, y        : scan position from the VGA controller
//   board_x, board_y      : board top-left corner
//   serve                 : launch request (level)
//   rgb                   : registered pixel colour
//   hit                   : one-cycle board bounce pulse
//   miss_count            : saturating miss counter
//   state                 : current game state
// master drives the inputs (VGA side / bench), slave is the generator.
// -----------------------------------------------------------------------------
interface ball_pixel_gen_if;

    logic        video_on;
    logic [9:0]  x;
    logic [9:0]  y;
    logic [9:0]  board_x;
    logic [9:0]  board_y;
    logic        serve;
    logic [11:0] rgb;
    logic        hit;
    logic [7:0]  miss_count;
    logic [1:0]  state;

    modport master (
        output video_on, x, y, board_x, board_y, serve,
        input  rgb, hit, miss_count, state
    );

    modport slave (
        input  video_on, x, y, board_x, board_y, serve,
        output rgb, hit, miss_count, state
    );

endinterface

// File: rtl/ball_pixel_gen_motion.sv
// -----------------------------------------------------------------------------
// ball_motion
// Owns the ball position and direction and advances them once per frame tick
// while the game is in PLAY. Walls reflect the ball, the board bounces it back
// up, and a ball that would leave through the bottom is reported as a miss.
// Ports:
//   clk, reset       : clock, asynchronous active-low reset
//   i_tick           : one-cycle frame tick
//   i_state          : current game state from the top-level FSM
//   i_boardX/Y       : board top-left corner (11-bit, zero-extended)
//   o_ballX/Y        : ball top-left corner
//   o_bounce         : board bounce happens on this tick
//   o_miss           : bottom miss happens on this tick
// -----------------------------------------------------------------------------
module ball_motion
    import pixel_gen_pkg::*;
#(
    parameter int H_ACTIVE    = DEF_H_ACTIVE,
    parameter int V_ACTIVE    = DEF_V_ACTIVE,
    parameter int BALL_SIZE   = 8,
    parameter int BOARD_WIDTH = 64,
    parameter int BALL_SPEED  = 2
) (
    input  logic   clk,
    input  logic   reset,
    input  logic   i_tick,
    input  state_t i_state,
    input  coord_t i_boardX,
    input  coord_t i_boardY,
    output coord_t o_ballX,
    output coord_t o_ballY,
    output logic   o_bounce,
    output logic   o_miss
);

    localparam coord_t ONE         = coord_t'(1);
    localparam coord_t SIZE        = coord_t'(BALL_SIZE);
    localparam coord_t SPEED       = coord_t'(BALL_SPEED);
    localparam coord_t RIGHT_LIMIT = coord_t'(H_ACTIVE);
    localparam coord_t X_MAX       = coord_t'(H_ACTIVE - BALL_SIZE);
    localparam coord_t Y_LAST      = coord_t'(V_ACTIVE - 1);
    localparam coord_t BOARD_W     = coord_t'(BOARD_WIDTH);
    localparam coord_t CENTER_X    = coord_t'(H_ACTIVE / 2 - BALL_SIZE / 2);
    localparam coord_t CENTER_Y    = coord_t'(V_ACTIVE / 2 - BALL_SIZE / 2);

    coord_t r_ballX;
    coord_t r_ballY;
    logic   r_dirLeft;
    logic   r_dirDown;

    logic   w_step;
    coord_t w_bottom;
    logic   w_overlap;
    logic   w_bounce;
    logic   w_miss;
    coord_t w_nextX;
    coord_t w_nextY;
    logic   w_nextLeft;
    logic   w_nextDown;

    // Bounce and miss detection for the current tick. The board test uses the
    // position before this tick's horizontal move, and a bounce always beats
    // a miss so a board sitting low on the screen still saves the ball.
    always_comb begin
        w_step    = i_tick && (i_state == PLAY);
        w_bottom  = r_ballY + SIZE - ONE;
        w_overlap = (r_ballX + SIZE - ONE >= i_boardX) &&
                    (r_ballX <= i_boardX + BOARD_W - ONE);
        w_bounce  = w_step && r_dirDown && (w_bottom < i_boardY) &&
                    (w_bottom + SPEED >= i_boardY) && w_overlap;
        w_miss    = w_step && r_dirDown && !w_bounce &&
                    (w_bottom + SPEED > Y_LAST);
    end

    // Horizontal axis: clamp against the side walls and reverse, otherwise
    // step by BALL_SPEED. Independent of anything happening vertically.
    always_comb begin
        w_nextX    = r_ballX;
        w_nextLeft = r_dirLeft;
        if (r_dirLeft) begin
            if (r_ballX <= SPEED) begin
                w_nextX    = '0;
                w_nextLeft = 1'b0;
            end else begin
                w_nextX = r_ballX - SPEED;
            end
        end else begin
            if (r_ballX + SIZE + SPEED >= RIGHT_LIMIT) begin
                w_nextX    = X_MAX;
                w_nextLeft = 1'b1;
            end else begin
                w_nextX = r_ballX + SPEED;
            end
        end
    end

    // Vertical axis: board bounce parks the ball right on top of the board,
    // the top wall clamps to row 0, and a miss leaves the row alone because
    // the ball disappears anyway.
    always_comb begin
        w_nextY    = r_ballY;
        w_nextDown = r_dirDown;
        if (w_bounce) begin
            w_nextY    = i_boardY - SIZE;
            w_nextDown = 1'b0;
        end else if (!r_dirDown) begin
            if (r_ballY <= SPEED) begin
                w_nextY    = '0;
                w_nextDown = 1'b1;
            end else begin
                w_nextY = r_ballY - SPEED;
            end
        end else if (!w_miss) begin
            w_nextY = r_ballY + SPEED;
        end
    end

    // Ball registers. Outside PLAY the ball is parked at the centre heading
    // up-right; doing this in MISS too (where the ball is invisible) means
    // the very first SERVE cycle after a respawn already shows it centred.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_ballX   <= CENTER_X;
            r_ballY   <= CENTER_Y;
            r_dirLeft <= 1'b0;
            r_dirDown <= 1'b0;
        end else if (i_state != PLAY) begin
            r_ballX   <= CENTER_X;
            r_ballY   <= CENTER_Y;
            r_dirLeft <= 1'b0;
            r_dirDown <= 1'b0;
        end else if (w_step) begin
            r_ballX   <= w_nextX;
            r_ballY   <= w_nextY;
            r_dirLeft <= w_nextLeft;
            r_dirDown <= w_nextDown;
        end
    end

    assign o_ballX  = r_ballX;
    assign o_ballY  = r_ballY;
    assign o_bounce = w_bounce;
    assign o_miss   = w_miss;

endmodule

// File: rtl/ball_pixel_gen.sv
// -----------------------------------------------------------------------------
// ball_pixel_gen
// Single-player ball game pixel generator. Runs the SERVE/PLAY/MISS game FSM,
// counts respawn frames and misses, and produces a registered colour for the
// pixel currently being scanned (ball over board over background).
// Ports:
//   clk    : system clock
//   reset  : asynchronous active-low reset
//   bus    : ball_pixel_gen_if.slave
//            in : video_on, x, y, board_x, board_y, serve
//            out: rgb (1-cycle latency), hit, miss_count, state
// -----------------------------------------------------------------------------
module ball_pixel_gen
    import pixel_gen_pkg::*;
#(
    parameter int          H_ACTIVE       = DEF_H_ACTIVE,
    parameter int          V_ACTIVE       = DEF_V_ACTIVE,
    parameter int          BALL_SIZE      = 8,
    parameter int          BOARD_WIDTH    = 64,
    parameter int          BOARD_HEIGHT   = 8,
    parameter int          BALL_SPEED     = 2,
    parameter int          RESPAWN_FRAMES = 60,
    parameter logic [11:0] BALL_RGB       = DEF_BALL_RGB,
    parameter logic [11:0] BOARD_RGB      = DEF_BOARD_RGB,
    parameter logic [11:0] BG_RGB         = DEF_BG_RGB
) (
    input logic             clk,
    input logic             reset,
    ball_pixel_gen_if.slave bus
);

    localparam int               CNT_W      = $clog2(RESPAWN_FRAMES + 1);
    localparam logic [CNT_W-1:0] LAST_FRAME = CNT_W'(RESPAWN_FRAMES - 1);
    localparam coord_t           TICK_ROW   = coord_t'(V_ACTIVE + 1);
    localparam coord_t           SIZE       = coord_t'(BALL_SIZE);
    localparam coord_t           BOARD_W    = coord_t'(BOARD_WIDTH);
    localparam coord_t           BOARD_H    = coord_t'(BOARD_HEIGHT);

    coord_t           w_pixX;
    coord_t           w_pixY;
    coord_t           w_boardX;
    coord_t           w_boardY;
    logic             w_tickMatch;
    logic             w_tick;
    logic             r_tickMatchPrev;

    state_t           r_state;
    state_t           w_nextState;
    logic [CNT_W-1:0] r_frameCnt;
    logic [7:0]       r_missCount;
    logic             r_hit;
    logic [11:0]      r_rgb;
    logic [11:0]      w_pixelRgb;
    logic             w_ballPix;
    logic             w_boardPix;

    coord_t           w_ballX;
    coord_t           w_ballY;
    logic             w_bounce;
    logic             w_miss;

    assign w_pixX   = {1'b0, bus.x};
    assign w_pixY   = {1'b0, bus.y};
    assign w_boardX = {1'b0, bus.board_x};
    assign w_boardY = {1'b0, bus.board_y};

    // The scan position can sit on the tick pixel for several system clocks
    // (pixel clock is slower), so the frame tick is the rising edge of the
    // match rather than the match itself.
    assign w_tickMatch = (w_pixX == '0) && (w_pixY == TICK_ROW);
    assign w_tick      = w_tickMatch && !r_tickMatchPrev;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_tickMatchPrev <= 1'b0;
        end else begin
            r_tickMatchPrev <= w_tickMatch;
        end
    end

    ball_motion #(
        .H_ACTIVE    (H_ACTIVE),
        .V_ACTIVE    (V_ACTIVE),
        .BALL_SIZE   (BALL_SIZE),
        .BOARD_WIDTH (BOARD_WIDTH),
        .BALL_SPEED  (BALL_SPEED)
    ) u_motion (
        .clk      (clk),
        .reset    (reset),
        .i_tick   (w_tick),
        .i_state  (r_state),
        .i_boardX (w_boardX),
        .i_boardY (w_boardY),
        .o_ballX  (w_ballX),
        .o_ballY  (w_ballY),
        .o_bounce (w_bounce),
        .o_miss   (w_miss)
    );

    // Game state register.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state <= SERVE;
        end else begin
            r_state <= w_nextState;
        end
    end

    // Game state transitions. serve is only looked at in SERVE, so holding
    // it high through a miss does not skip the respawn delay.
    always_comb begin
        w_nextState = r_state;
        case (r_state)
            SERVE: if (bus.serve) w_nextState = PLAY;
            PLAY:  if (w_miss) w_nextState = MISS;
            MISS:  if (w_tick && (r_frameCnt == LAST_FRAME)) w_nextState = SERVE;
            default: w_nextState = SERVE;
        endcase
    end

    // Respawn frame counter: restarts on every miss and counts ticks spent in
    // MISS; it wraps to zero on the tick that sends the game back to SERVE.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_frameCnt <= '0;
        end else if (w_miss) begin
            r_frameCnt <= '0;
        end else if ((r_state == MISS) && w_tick) begin
            r_frameCnt <= (r_frameCnt == LAST_FRAME) ? '0 : r_frameCnt + CNT_W'(1);
        end
    end

    // Miss counter sticks at 255 instead of rolling over.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_missCount <= '0;
        end else if (w_miss && (r_missCount != 8'hFF)) begin
            r_missCount <= r_missCount + 8'd1;
        end
    end

    // Bounce pulse, registered so it lines up with the updated ball position.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_hit <= 1'b0;
        end else begin
            r_hit <= w_bounce;
        end
    end

    // Pixel colour selection: blanking first, then the ball (hidden during
    // MISS), then the board, then background.
    always_comb begin
        w_ballPix  = (r_state != MISS) &&
                     inSpan(w_pixX, w_ballX, SIZE) && inSpan(w_pixY, w_ballY, SIZE);
        w_boardPix = inSpan(w_pixX, w_boardX, BOARD_W) && inSpan(w_pixY, w_boardY, BOARD_H);
        w_pixelRgb = BG_RGB;
        if (!bus.video_on) begin
            w_pixelRgb = BLANK_RGB;
        end else if (w_ballPix) begin
            w_pixelRgb = BALL_RGB;
        end else if (w_boardPix) begin
            w_pixelRgb = BOARD_RGB;
        end
    end

    // Colour output register (one clock of latency from x/y to rgb).
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_rgb <= BLANK_RGB;
        end else begin
            r_rgb <= w_pixelRgb;
        end
    end

    assign bus.rgb        = r_rgb;
    assign bus.hit        = r_hit;
    assign bus.miss_count = r_missCount;
    assign bus.state      = r_state;

endmodule
